// File: rtl/comparator_seq.sv
// Multi-cycle magnitude comparator: walks two WIDTH-bit operands MSB-first,
// CHUNK bits per clock, stopping at the first differing chunk.
module comparator_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [IW-1:0]    idx;

  logic [WIDTH-1:0] bias;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic             chunk_ne;
  logic             chunk_gt;

  // Flipping both sign bits maps two's complement onto offset binary, so the
  // chunk walk below only ever needs an unsigned compare.
  always_comb begin
    bias            = '0;
    bias[WIDTH-1]   = signed_mode;
  end

  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IW'(i)) begin
        chunk_a = ra[i*CHUNK +: CHUNK];
        chunk_b = rb[i*CHUNK +: CHUNK];
      end
    end
    chunk_ne = (chunk_a != chunk_b);
    chunk_gt = (chunk_a > chunk_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      a_gt_b <= 1'b0;
      a_eq_b <= 1'b0;
      a_lt_b <= 1'b0;
    end else begin
      case (state)
        // DONE accepts start just like IDLE so back-to-back compares have no bubble.
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= in1 ^ bias;
            rb    <= in2 ^ bias;
            idx   <= LAST_IDX;
            busy  <= 1'b1;
            state <= CMP;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        CMP: begin
          if (chunk_ne) begin
            a_gt_b <= chunk_gt;
            a_lt_b <= ~chunk_gt;
            a_eq_b <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else if (idx == '0) begin
            a_gt_b <= 1'b0;
            a_lt_b <= 1'b0;
            a_eq_b <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_seq.sv
// Directed bench for comparator_seq: an 8-bit/2-bit-chunk instance and a
// 3-bit/1-bit-chunk instance share one clock and a common stimulus driver.
module tb_comparator_seq;

  logic clk;
  logic rst_n;

  logic       use3;
  logic       start_r;
  logic       mode_r;
  logic [7:0] in1_r;
  logic [7:0] in2_r;

  logic busy8, done8, gt8, eq8, lt8;
  logic busy3, done3, gt3, eq3, lt3;

  logic       cur_busy;
  logic       cur_done;
  logic [2:0] cur_flags;

  int checks;
  int errors;

  comparator_seq #(.WIDTH(8), .CHUNK(2)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_r & ~use3),
    .signed_mode(mode_r),
    .in1        (in1_r),
    .in2        (in2_r),
    .busy       (busy8),
    .done       (done8),
    .a_gt_b     (gt8),
    .a_eq_b     (eq8),
    .a_lt_b     (lt8)
  );

  comparator_seq #(.WIDTH(3), .CHUNK(1)) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_r & use3),
    .signed_mode(mode_r),
    .in1        (in1_r[2:0]),
    .in2        (in2_r[2:0]),
    .busy       (busy3),
    .done       (done3),
    .a_gt_b     (gt3),
    .a_eq_b     (eq3),
    .a_lt_b     (lt3)
  );

  assign cur_busy  = use3 ? busy3 : busy8;
  assign cur_done  = use3 ? done3 : done8;
  assign cur_flags = use3 ? {gt3, eq3, lt3} : {gt8, eq8, lt8};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic mode);
    @(negedge clk);
    in1_r   = a;
    in2_r   = b;
    mode_r  = mode;
    start_r = 1'b1;
    @(posedge clk);
    #1;
    start_r = 1'b0;
  endtask

  // Counts edges from the start edge until done is seen (bounded).
  task automatic waitDone(output int m, output int busy_cnt);
    m        = 0;
    busy_cnt = 0;
    while (cur_done !== 1'b1 && m < 20) begin
      if (cur_busy === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
      m++;
    end
  endtask

  task automatic runCheck(input string tag, input logic sel3,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic mode, input logic [2:0] exp_flags,
                          input int exp_m);
    int m;
    int bc;
    use3 = sel3;
    applyStimulus(a, b, mode);
    checkOutput({tag, "_busy_rise"}, 32'(cur_busy), 32'd1);
    waitDone(m, bc);
    checkOutput({tag, "_m"}, 32'(m), 32'(exp_m));
    checkOutput({tag, "_busy_cycles"}, 32'(bc), 32'(exp_m));
    checkOutput({tag, "_flags"}, 32'(cur_flags), 32'(exp_flags));
    checkOutput({tag, "_busy_at_done"}, 32'(cur_busy), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_fall"}, 32'(cur_done), 32'd0);
    checkOutput({tag, "_flags_hold"}, 32'(cur_flags), 32'(exp_flags));
  endtask

  initial begin
    int m;
    int bc;
    int dones;
    checks  = 0;
    errors  = 0;
    use3    = 1'b0;
    start_r = 1'b0;
    mode_r  = 1'b0;
    in1_r   = 8'h00;
    in2_r   = 8'h00;
    rst_n   = 1'b0;

    // Reset values, before any clock edge
    #3;
    checkOutput("rst8_outs", 32'({busy8, done8, gt8, eq8, lt8}), 32'd0);
    checkOutput("rst3_outs", 32'({busy3, done3, gt3, eq3, lt3}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle3_flags", 32'({gt3, eq3, lt3}), 32'd0);
    checkOutput("idle8_flags", 32'({gt8, eq8, lt8}), 32'd0);

    // 3-bit instance: 101 < 111 resolved on the middle bit
    runCheck("w3_lt", 1'b1, 8'h05, 8'h07, 1'b0, 3'b001, 2);
    // 3-bit signed: -4 < 3 decided on the sign bit
    runCheck("w3_s_lt", 1'b1, 8'h04, 8'h03, 1'b1, 3'b001, 1);

    // 8-bit instance
    runCheck("c0_40_u", 1'b0, 8'hC0, 8'h40, 1'b0, 3'b100, 1);
    runCheck("c0_40_s", 1'b0, 8'hC0, 8'h40, 1'b1, 3'b001, 1);
    runCheck("a5_a7_u", 1'b0, 8'hA5, 8'hA7, 1'b0, 3'b001, 4);
    runCheck("5a_eq",   1'b0, 8'h5A, 8'h5A, 1'b0, 3'b010, 4);
    runCheck("ff_fe_s", 1'b0, 8'hFF, 8'hFE, 1'b1, 3'b100, 4);

    // Operand and mode changes during CMP must not disturb the compare
    use3 = 1'b0;
    applyStimulus(8'hFF, 8'hFE, 1'b1);
    in1_r  = 8'h00;
    in2_r  = 8'hFF;
    mode_r = 1'b0;
    waitDone(m, bc);
    checkOutput("opchg_m", 32'(m), 32'd4);
    checkOutput("opchg_flags", 32'(cur_flags), 32'b100);

    // start pulsed during CMP is ignored: one done, original result
    applyStimulus(8'h10, 8'h13, 1'b0);
    @(negedge clk);
    in1_r   = 8'hFF;
    in2_r   = 8'h00;
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (cur_done === 1'b1) dones++;
    end
    checkOutput("cmp_start_dones", 32'(dones), 32'd1);
    checkOutput("cmp_start_flags", 32'(cur_flags), 32'b001);

    // Back-to-back: start raised during the DONE cycle
    applyStimulus(8'h5A, 8'h5A, 1'b0);
    waitDone(m, bc);
    checkOutput("b2b_first_m", 32'(m), 32'd4);
    in1_r   = 8'h01;
    in2_r   = 8'h02;
    start_r = 1'b1;
    @(posedge clk);
    #1;
    start_r = 1'b0;
    checkOutput("b2b_busy_rise", 32'(cur_busy), 32'd1);
    checkOutput("b2b_done_low", 32'(cur_done), 32'd0);
    checkOutput("b2b_old_flags", 32'(cur_flags), 32'b010);
    waitDone(m, bc);
    checkOutput("b2b_second_m", 32'(m), 32'd4);
    checkOutput("b2b_second_flags", 32'(cur_flags), 32'b001);
    @(posedge clk);
    #1;

    // Reset in the second CMP cycle aborts the compare immediately
    applyStimulus(8'hA5, 8'hA7, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_outs", 32'({busy8, done8, gt8, eq8, lt8}), 32'd0);
    #4;
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (cur_done === 1'b1) dones++;
    end
    checkOutput("midrst_no_done", 32'(dones), 32'd0);
    runCheck("post_rst_u", 1'b0, 8'h80, 8'h7F, 1'b0, 3'b100, 1);
    runCheck("post_rst_s", 1'b0, 8'h80, 8'h7F, 1'b1, 3'b001, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
